// File: rtl/dvs_line_xfer_sched.sv
// -----------------------------------------------------------------------------
// dvs_line_xfer_sched
//   Sequences BRAM<->DDR block transfers for the DVS line buffer. Each
//   write_new_line event triggers two CDMA commands: write the finished BRAM
//   block out to DDR, then read the next block of the frame image back into
//   BRAM. The module tracks which block currently sits in BRAM, realigns to
//   block 0 on new_frame, and raises sticky overrun / transfer-error / timeout
//   flags.
//
// Ports
//   pclk, reset      clock (posedge) and asynchronous active-high reset
//   new_frame        frame-start pulse (1-2 cycles high)
//   write_new_line   block-complete pulse (1-2 cycles high)
//   cmd_valid/ready  CDMA command handshake
//   cmd_src/dst/len  CDMA command payload (byte addresses, byte count)
//   cmd_done/err     CDMA completion pulse and its error qualifier
//   block_idx        index of the block held in BRAM
//   busy             high whenever a transfer sequence is in progress
//   frame_done       one-cycle pulse after the last block of a frame is written
//   overrun          sticky: request dropped because one was already queued
//   xfer_err         sticky: a transfer completed with cmd_err
//   timeout          sticky: a transfer did not complete in TIMEOUT_CYC cycles
//   clear_flags      clears the sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module dvs_line_xfer_sched #(
    parameter logic [31:0] BRAM_BASE        = 32'hC000_0000,
    parameter logic [31:0] DDR_BASE         = 32'h1000_0000,
    parameter int          BLOCK_BYTES      = 8192,
    parameter int          BLOCKS_PER_FRAME = 4,
    parameter logic [15:0] TIMEOUT_CYC      = 16'd50000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        new_frame,
    input  logic        write_new_line,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_src,
    output logic [31:0] cmd_dst,
    output logic [22:0] cmd_len,
    input  logic        cmd_done,
    input  logic        cmd_err,
    output logic [1:0]  block_idx,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        xfer_err,
    output logic        timeout,
    input  logic        clear_flags
);

    localparam logic [22:0] LEN      = 23'(BLOCK_BYTES);
    localparam logic [1:0]  LAST_IDX = 2'(BLOCKS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_WAIT,
        ST_RD_CMD,
        ST_RD_WAIT
    } state_t;

    // ---------------------------------------------------------------------
    // Pulse inputs: register, then take the rising edge of the registered
    // copy so a 1- or 2-cycle pulse yields exactly one event.
    // bit 0 = write_new_line, bit 1 = new_frame
    // ---------------------------------------------------------------------
    logic [1:0] pulse_in;
    logic [1:0] pulse_q_reg;
    logic [1:0] pulse_qq_reg;
    logic [1:0] pulse_edge;

    assign pulse_in = {new_frame, write_new_line};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            always_ff @(posedge pclk or posedge reset) begin
                if (reset) begin
                    pulse_q_reg[gi]  <= 1'b0;
                    pulse_qq_reg[gi] <= 1'b0;
                end else begin
                    pulse_q_reg[gi]  <= pulse_in[gi];
                    pulse_qq_reg[gi] <= pulse_q_reg[gi];
                end
            end
            assign pulse_edge[gi] = pulse_q_reg[gi] & ~pulse_qq_reg[gi];
        end
    endgenerate

    logic wnl_edge;
    logic nf_edge;
    assign wnl_edge = pulse_edge[0];
    assign nf_edge  = pulse_edge[1];

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t      state_reg;
    logic [1:0]  block_idx_reg;
    logic        req_pend_reg;
    logic        frame_pend_reg;
    logic [15:0] tmo_cnt_reg;
    logic        cmd_valid_reg;
    logic [31:0] cmd_src_reg;
    logic [31:0] cmd_dst_reg;
    logic [22:0] cmd_len_reg;
    logic        frame_done_reg;
    logic        overrun_reg;
    logic        xfer_err_reg;
    logic        timeout_reg;

    // A frame realignment pending or arriving in IDLE takes effect before a
    // simultaneous request is serviced, so the write uses block 0.
    logic [1:0]  wr_idx_next;
    logic [1:0]  nxt_idx_next;
    logic [31:0] wr_dst_next;
    logic [31:0] rd_src_next;

    assign wr_idx_next  = (nf_edge || frame_pend_reg) ? 2'd0 : block_idx_reg;
    assign nxt_idx_next = (block_idx_reg == LAST_IDX) ? 2'd0 : block_idx_reg + 2'd1;
    assign wr_dst_next  = DDR_BASE + 32'(wr_idx_next)  * 32'(BLOCK_BYTES);
    assign rd_src_next  = DDR_BASE + 32'(nxt_idx_next) * 32'(BLOCK_BYTES);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            block_idx_reg  <= 2'd0;
            req_pend_reg   <= 1'b0;
            frame_pend_reg <= 1'b0;
            tmo_cnt_reg    <= 16'd0;
            cmd_valid_reg  <= 1'b0;
            cmd_src_reg    <= 32'd0;
            cmd_dst_reg    <= 32'd0;
            cmd_len_reg    <= 23'd0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            xfer_err_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            // Clear first so any set below in the same cycle wins.
            if (clear_flags) begin
                overrun_reg  <= 1'b0;
                xfer_err_reg <= 1'b0;
                timeout_reg  <= 1'b0;
            end

            // Events arriving during a sequence are latched for later.
            if (state_reg != ST_IDLE) begin
                if (wnl_edge) begin
                    if (req_pend_reg) overrun_reg  <= 1'b1;
                    else              req_pend_reg <= 1'b1;
                end
                if (nf_edge) frame_pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (nf_edge || frame_pend_reg) begin
                        block_idx_reg  <= 2'd0;
                        frame_pend_reg <= 1'b0;
                    end
                    if (req_pend_reg || wnl_edge) begin
                        cmd_src_reg  <= BRAM_BASE;
                        cmd_dst_reg  <= wr_dst_next;
                        cmd_len_reg  <= LEN;
                        // Servicing the queued request while a new edge
                        // arrives leaves the new one queued.
                        req_pend_reg <= req_pend_reg & wnl_edge;
                        state_reg    <= ST_WR_CMD;
                    end
                end

                ST_WR_CMD, ST_RD_CMD: begin
                    if (!cmd_valid_reg) begin
                        cmd_valid_reg <= 1'b1;
                    end else if (cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        tmo_cnt_reg   <= 16'd0;
                        state_reg     <= (state_reg == ST_WR_CMD) ? ST_WR_WAIT : ST_RD_WAIT;
                    end
                end

                ST_WR_WAIT, ST_RD_WAIT: begin
                    if (cmd_done) begin
                        if (cmd_err) xfer_err_reg <= 1'b1;
                        if (state_reg == ST_WR_WAIT) begin
                            if (block_idx_reg == LAST_IDX) frame_done_reg <= 1'b1;
                            cmd_src_reg <= rd_src_next;
                            cmd_dst_reg <= BRAM_BASE;
                            cmd_len_reg <= LEN;
                            state_reg   <= ST_RD_CMD;
                        end else begin
                            // A frame start seen during the sequence overrides
                            // the normal advance to the next block.
                            block_idx_reg  <= (frame_pend_reg || nf_edge) ? 2'd0 : nxt_idx_next;
                            frame_pend_reg <= 1'b0;
                            state_reg      <= ST_IDLE;
                        end
                    end else if (tmo_cnt_reg == TIMEOUT_CYC - 16'd1) begin
                        // Abandon the sequence; any frame realignment stays
                        // pending and is applied from IDLE.
                        timeout_reg  <= 1'b1;
                        req_pend_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_valid  = cmd_valid_reg;
    assign cmd_src    = cmd_src_reg;
    assign cmd_dst    = cmd_dst_reg;
    assign cmd_len    = cmd_len_reg;
    assign block_idx  = block_idx_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;
    assign xfer_err   = xfer_err_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_dvs_line_xfer_sched.sv
// -----------------------------------------------------------------------------
// tb_dvs_line_xfer_sched
//   Directed bench for dvs_line_xfer_sched. Inputs change 1 ns after each
//   rising pclk edge and outputs are read at that same point; accept and
//   frame_done events are counted on the falling edge.
// -----------------------------------------------------------------------------
module tb_dvs_line_xfer_sched;

    localparam logic [31:0] BRAM = 32'hC000_0000;

    logic        pclk;
    logic        reset;
    logic        new_frame;
    logic        write_new_line;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src;
    logic [31:0] cmd_dst;
    logic [22:0] cmd_len;
    logic        cmd_done;
    logic        cmd_err;
    logic [1:0]  block_idx;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        xfer_err;
    logic        timeout;
    logic        clear_flags;

    dvs_line_xfer_sched #(
        .TIMEOUT_CYC(16'd100)
    ) dut (
        .pclk          (pclk),
        .reset         (reset),
        .new_frame     (new_frame),
        .write_new_line(write_new_line),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src       (cmd_src),
        .cmd_dst       (cmd_dst),
        .cmd_len       (cmd_len),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .block_idx     (block_idx),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .xfer_err      (xfer_err),
        .timeout       (timeout),
        .clear_flags   (clear_flags)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int fd_cnt = 0;

    always @(negedge pclk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (frame_done) fd_cnt++;
    end

    typedef struct {
        int          hold;
        int          dly;
        logic [31:0] wr_dst;
        logic [31:0] rd_src;
        logic [1:0]  idx;
        int          fd;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pulse_wnl();
        write_new_line = 1'b1;
        tick();
        write_new_line = 1'b0;
    endtask

    // Wait (bounded) for cmd_valid, optionally hold ready low, then accept.
    task automatic accept_cmd(input int hold, output logic [31:0] src, output logic [31:0] dst,
                              output logic [31:0] len, output bit stable);
        int n;
        n = 0;
        stable = 1'b1;
        while (!cmd_valid && n < 40) begin
            tick();
            n++;
        end
        chk("cmd_valid_seen", {31'd0, cmd_valid}, 32'd1);
        src = cmd_src;
        dst = cmd_dst;
        len = {9'd0, cmd_len};
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!cmd_valid || cmd_src !== src || cmd_dst !== dst || {9'd0, cmd_len} !== len)
                stable = 1'b0;
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("valid_drop", {31'd0, cmd_valid}, 32'd0);
    endtask

    // cmd_done is sampled on the dly-th rising edge after acceptance.
    task automatic send_done(input int dly, input logic err);
        for (int i = 0; i < dly - 1; i++) tick();
        cmd_done = 1'b1;
        cmd_err  = err;
        tick();
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
    endtask

    task automatic do_seq(input int hold, input int dly,
                          output logic [31:0] ws, output logic [31:0] wd, output logic [31:0] wl,
                          output logic [31:0] rs, output logic [31:0] rd, output bit wstab);
        logic [31:0] l2;
        bit          s2;
        pulse_wnl();
        accept_cmd(hold, ws, wd, wl, wstab);
        send_done(dly, 1'b0);
        accept_cmd(0, rs, rd, l2, s2);
        send_done(dly, 1'b0);
        tick();
        $display("seq wr %h->%h rd %h->%h idx=%0d", ws, wd, rs, rd, block_idx);
    endtask

    initial begin
        logic [31:0] ws, wd, wl, rs, rd;
        bit          st;
        int          a0;

        vecs[0] = '{0,  10, 32'h1000_0000, 32'h1000_2000, 2'd1, 0};
        vecs[1] = '{0,  10, 32'h1000_2000, 32'h1000_4000, 2'd2, 0};
        vecs[2] = '{0,  10, 32'h1000_4000, 32'h1000_6000, 2'd3, 0};
        vecs[3] = '{0,  10, 32'h1000_6000, 32'h1000_0000, 2'd0, 1};
        vecs[4] = '{20, 10, 32'h1000_0000, 32'h1000_2000, 2'd1, 1};

        reset = 1'b1;
        new_frame = 1'b0;
        write_new_line = 1'b0;
        cmd_ready = 1'b0;
        cmd_done = 1'b0;
        cmd_err = 1'b0;
        clear_flags = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_src", cmd_src, 32'd0);
        chk("rst_dst", cmd_dst, 32'd0);
        chk("rst_len", {9'd0, cmd_len}, 32'd0);
        chk("rst_idx", {30'd0, block_idx}, 32'd0);
        chk("rst_flags", {27'd0, busy, frame_done, overrun, xfer_err, timeout}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Full frame of line transfers, last row with ready held low 20 cycles
        for (int i = 0; i < 5; i++) begin
            a0 = acc_cnt;
            do_seq(vecs[i].hold, vecs[i].dly, ws, wd, wl, rs, rd, st);
            chk("wr_src", ws, BRAM);
            chk("wr_dst", wd, vecs[i].wr_dst);
            chk("wr_len", wl, 32'd8192);
            chk("wr_stable", {31'd0, st}, 32'd1);
            chk("rd_src", rs, vecs[i].rd_src);
            chk("rd_dst", rd, BRAM);
            chk("idx_after", {30'd0, block_idx}, {30'd0, vecs[i].idx});
            chk("frame_done_cnt", fd_cnt, vecs[i].fd);
            chk("accepts", acc_cnt - a0, 32'd2);
            chk("busy_end", {31'd0, busy}, 32'd0);
        end

        // Queue one request during WR_WAIT, overrun on the next
        a0 = acc_cnt;
        pulse_wnl();
        accept_cmd(0, ws, wd, wl, st);
        chk("q_wr_dst_a", wd, 32'h1000_2000);
        pulse_wnl();
        tick(); tick();
        chk("overrun_after_2nd", {31'd0, overrun}, 32'd0);
        pulse_wnl();
        tick(); tick();
        chk("overrun_after_3rd", {31'd0, overrun}, 32'd1);
        send_done(10, 1'b0);
        accept_cmd(0, rs, rd, wl, st);
        chk("q_rd_src_a", rs, 32'h1000_4000);
        send_done(10, 1'b0);
        accept_cmd(0, ws, wd, wl, st);
        chk("q_wr_dst_b", wd, 32'h1000_4000);
        send_done(10, 1'b0);
        accept_cmd(0, rs, rd, wl, st);
        chk("q_rd_src_b", rs, 32'h1000_6000);
        send_done(10, 1'b0);
        repeat (30) tick();
        chk("q_accepts", acc_cnt - a0, 32'd4);
        chk("q_idx", {30'd0, block_idx}, 32'd3);
        chk("q_busy", {31'd0, busy}, 32'd0);
        $display("queue test accepts=%0d overrun=%0d", acc_cnt - a0, overrun);

        // new_frame coinciding with write_new_line in IDLE: block 0 first
        new_frame = 1'b1;
        write_new_line = 1'b1;
        tick();
        new_frame = 1'b0;
        write_new_line = 1'b0;
        accept_cmd(0, ws, wd, wl, st);
        chk("nf_coinc_wr_dst", wd, 32'h1000_0000);
        send_done(10, 1'b0);
        accept_cmd(0, rs, rd, wl, st);
        chk("nf_coinc_rd_src", rs, 32'h1000_2000);
        send_done(10, 1'b0);
        tick();
        chk("nf_coinc_idx", {30'd0, block_idx}, 32'd1);
        do_seq(0, 10, ws, wd, wl, rs, rd, st);
        chk("pre_nf_idx", {30'd0, block_idx}, 32'd2);

        // new_frame during RD_WAIT at block 2
        pulse_wnl();
        accept_cmd(0, ws, wd, wl, st);
        chk("nf_wr_dst", wd, 32'h1000_4000);
        send_done(10, 1'b0);
        accept_cmd(0, rs, rd, wl, st);
        chk("nf_rd_src", rs, 32'h1000_6000);
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        tick(); tick();
        chk("nf_busy_mid", {31'd0, busy}, 32'd1);
        send_done(10, 1'b0);
        tick();
        chk("nf_idx", {30'd0, block_idx}, 32'd0);
        chk("nf_fd_cnt", fd_cnt, 32'd1);
        do_seq(0, 10, ws, wd, wl, rs, rd, st);
        chk("nf_next_wr_dst", wd, 32'h1000_0000);

        // Timeout: no cmd_done after the write is accepted
        pulse_wnl();
        accept_cmd(0, ws, wd, wl, st);
        repeat (99) tick();
        chk("tmo_before", {31'd0, timeout}, 32'd0);
        chk("tmo_busy_before", {31'd0, busy}, 32'd1);
        tick();
        chk("tmo_at_100", {31'd0, timeout}, 32'd1);
        chk("tmo_idle", {31'd0, busy}, 32'd0);
        chk("tmo_idx", {30'd0, block_idx}, 32'd1);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick(); tick();
        chk("late_done_busy", {31'd0, busy}, 32'd0);
        chk("late_done_valid", {31'd0, cmd_valid}, 32'd0);
        chk("late_done_idx", {30'd0, block_idx}, 32'd1);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("clr_timeout", {31'd0, timeout}, 32'd0);
        chk("clr_overrun", {31'd0, overrun}, 32'd0);

        // cmd_err on the write, then async reset in RD_CMD
        pulse_wnl();
        accept_cmd(0, ws, wd, wl, st);
        chk("err_wr_dst", wd, 32'h1000_2000);
        send_done(10, 1'b1);
        chk("xfer_err_set", {31'd0, xfer_err}, 32'd1);
        tick();
        chk("rd_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        chk("rd_cmd_src", cmd_src, 32'h1000_4000);
        reset = 1'b1;
        #2;
        chk("arst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("arst_src", cmd_src, 32'd0);
        chk("arst_dst", cmd_dst, 32'd0);
        chk("arst_len", {9'd0, cmd_len}, 32'd0);
        chk("arst_idx", {30'd0, block_idx}, 32'd0);
        chk("arst_flags", {27'd0, busy, frame_done, overrun, xfer_err, timeout}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
